// File: rtl/apb3_arb_pkg.sv
// -----------------------------------------------------------------------------
// apb3_arb_pkg
// Shared types and constants for the two-master APB3 arbiter:
//   arb_state_t     : arbiter FSM states (IDLE, SETUP, ACCESS)
//   GNT_*           : one-hot grant encodings (bit0 = M0, bit1 = M1)
//   TO_CNT_W        : timeout counter width for the default TIMEOUT_CYCLES
//   to_cnt_width()  : timeout counter width for any TIMEOUT_CYCLES value
// -----------------------------------------------------------------------------
package apb3_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;
  localparam int unsigned TO_CNT_W = $clog2(DEFAULT_TIMEOUT_CYCLES);

  // The counter only has to reach TIMEOUT_CYCLES-1, so $clog2 bits suffice.
  function automatic int unsigned to_cnt_width(input int unsigned cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/apb3_master_arbiter_rr.sv
// -----------------------------------------------------------------------------
// rr_arbiter_2
// Combinational two-request round-robin picker.
//   req[1:0] : request vector (bit0 = M0, bit1 = M1)
//   last_m1  : last-grant pointer, 1 when M1 received the most recent grant
//   gnt[1:0] : one-hot grant, GNT_NONE when nobody requests
// The pointer register lives in the parent so it only moves on a real grant.
// -----------------------------------------------------------------------------
module rr_arbiter_2
  import apb3_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_m1,
  output logic [1:0] gnt
);

  // On contention the master that was not granted last time wins.
  always_comb begin
    gnt = GNT_NONE;
    case (req)
      2'b01:   gnt = GNT_M0;
      2'b10:   gnt = GNT_M1;
      2'b11:   gnt = last_m1 ? GNT_M0 : GNT_M1;
      default: gnt = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/apb3_master_arbiter.sv
// -----------------------------------------------------------------------------
// apb3_master_arbiter
// Shares one downstream APB3 master port between two upstream masters
// (M0 = CPU, M1 = secondary sequencer) with round-robin arbitration and one
// complete transfer per grant. Downstream transfer signals are registered
// copies of the granted request; the non-granted master sees PREADY_Mx = 0.
//
// Ports:
//   PCLK, PRESET                 : clock, asynchronous active-high reset
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA_M0/M1 : upstream requests
//   PREADY/PRDATA/PSLVERR_M0/M1  : upstream responses (combinational)
//   PSEL/PENABLE/PADDR/PWRITE/PWDATA       : downstream request (registered)
//   PRDATA/PREADY/PSLVERR        : downstream response
//   GNT[1:0]                     : one-hot grant status (bit0 = M0)
//
// Optional feature macro APB_ARB_TIMEOUT_EN: aborts an ACCESS phase that has
// waited TIMEOUT_CYCLES cycles, answering the master with PSLVERR.
// -----------------------------------------------------------------------------
module apb3_master_arbiter
  import apb3_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL_M0,
  input  logic                  PSEL_M1,
  input  logic                  PENABLE_M0,
  input  logic                  PENABLE_M1,
  input  logic [ADDR_WIDTH-1:0] PADDR_M0,
  input  logic [ADDR_WIDTH-1:0] PADDR_M1,
  input  logic                  PWRITE_M0,
  input  logic                  PWRITE_M1,
  input  logic [DATA_WIDTH-1:0] PWDATA_M0,
  input  logic [DATA_WIDTH-1:0] PWDATA_M1,
  output logic                  PREADY_M0,
  output logic                  PREADY_M1,
  output logic [DATA_WIDTH-1:0] PRDATA_M0,
  output logic [DATA_WIDTH-1:0] PRDATA_M1,
  output logic                  PSLVERR_M0,
  output logic                  PSLVERR_M1,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR,
  output logic [1:0]            GNT
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("apb3_master_arbiter: TIMEOUT_CYCLES must be in 2..65535");
  end

  arb_state_t            state_q, state_d;
  logic [1:0]            gnt_q, gnt_d;
  logic                  last_m1_q, last_m1_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [1:0]            pick;
  logic                  timeout;
  logic                  xfer_done;

  // PENABLE_Mx carries no sequencing information: the setup/access split is
  // regenerated downstream by this arbiter.
  logic unused_penable;
  assign unused_penable = PENABLE_M0 ^ PENABLE_M1;

  rr_arbiter_2 u_rr (
    .req     ({PSEL_M1, PSEL_M0}),
    .last_m1 (last_m1_q),
    .gnt     (pick)
  );

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = to_cnt_width(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts ACCESS cycles without PREADY; a late PREADY still wins over abort.
  assign timeout = (state_q == ACCESS) && !PREADY &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == ACCESS && !PREADY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  assign xfer_done = (state_q == ACCESS) && (PREADY || timeout);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_m1_d = last_m1_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    case (state_q)
      IDLE: begin
        if (pick != GNT_NONE) begin
          state_d   = SETUP;
          gnt_d     = pick;
          last_m1_d = pick[1];
          psel_d    = 1'b1;
          penable_d = 1'b0;
          paddr_d   = pick[1] ? PADDR_M1  : PADDR_M0;
          pwrite_d  = pick[1] ? PWRITE_M1 : PWRITE_M0;
          pwdata_d  = pick[1] ? PWDATA_M1 : PWDATA_M0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
      end
      ACCESS: begin
        // Address and write data are left as they were after completion.
        if (xfer_done) begin
          state_d   = IDLE;
          gnt_d     = GNT_NONE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      default: begin
        state_d   = IDLE;
        gnt_d     = GNT_NONE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // Pointer resets to M1 so that M0 wins the first contention.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q   <= IDLE;
      gnt_q     <= GNT_NONE;
      last_m1_q <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_m1_q <= last_m1_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign PSEL    = psel_q;
  assign PENABLE = penable_q;
  assign PADDR   = paddr_q;
  assign PWRITE  = pwrite_q;
  assign PWDATA  = pwdata_q;
  assign GNT     = gnt_q;

  // A timeout abort answers with an error and suppresses the slave's data.
  assign PREADY_M0  = gnt_q[0] & xfer_done;
  assign PREADY_M1  = gnt_q[1] & xfer_done;
  assign PSLVERR_M0 = PREADY_M0 & (PSLVERR | timeout);
  assign PSLVERR_M1 = PREADY_M1 & (PSLVERR | timeout);
  assign PRDATA_M0  = (gnt_q[0] && !timeout) ? PRDATA : '0;
  assign PRDATA_M1  = (gnt_q[1] && !timeout) ? PRDATA : '0;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// -----------------------------------------------------------------------------
// tb_apb3_master_arbiter
// Self-checking bench for apb3_master_arbiter: reset values, a table of single
// transfers, hand-written multi-cycle sequences (contention, alternation,
// long wait / timeout, reset during ACCESS) and a randomized run against a
// transfer-window reference model.
// -----------------------------------------------------------------------------
module tb_apb3_master_arbiter;
  import apb3_arb_pkg::*;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int TO_CYC = 4;
`else
  localparam int TO_CYC = 256;
`endif

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        PSEL_M0, PSEL_M1, PENABLE_M0, PENABLE_M1;
  logic [31:0] PADDR_M0, PADDR_M1, PWDATA_M0, PWDATA_M1;
  logic        PWRITE_M0, PWRITE_M1;
  logic        PREADY_M0, PREADY_M1, PSLVERR_M0, PSLVERR_M1;
  logic [31:0] PRDATA_M0, PRDATA_M1;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  GNT;

  int checks = 0;
  int errors = 0;

  always #5 PCLK = ~PCLK;

  apb3_master_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TO_CYC)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .PSEL_M0    (PSEL_M0),
    .PSEL_M1    (PSEL_M1),
    .PENABLE_M0 (PENABLE_M0),
    .PENABLE_M1 (PENABLE_M1),
    .PADDR_M0   (PADDR_M0),
    .PADDR_M1   (PADDR_M1),
    .PWRITE_M0  (PWRITE_M0),
    .PWRITE_M1  (PWRITE_M1),
    .PWDATA_M0  (PWDATA_M0),
    .PWDATA_M1  (PWDATA_M1),
    .PREADY_M0  (PREADY_M0),
    .PREADY_M1  (PREADY_M1),
    .PRDATA_M0  (PRDATA_M0),
    .PRDATA_M1  (PRDATA_M1),
    .PSLVERR_M0 (PSLVERR_M0),
    .PSLVERR_M1 (PSLVERR_M1),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR),
    .GNT        (GNT)
  );

  // One directed transfer: who requests, what the winner sends, how the
  // slave answers, and which grant is expected.
  typedef struct {
    logic        req0;
    logic        req1;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  exp_gnt;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s0, input logic s1,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic w0, input logic w1,
                               input logic [31:0] d0, input logic [31:0] d1,
                               input logic rdy, input logic err,
                               input logic [31:0] rdata);
    PSEL_M0 = s0;   PSEL_M1 = s1;
    PENABLE_M0 = 1'b0; PENABLE_M1 = 1'b0;
    PADDR_M0 = a0;  PADDR_M1 = a1;
    PWRITE_M0 = w0; PWRITE_M1 = w1;
    PWDATA_M0 = d0; PWDATA_M1 = d1;
    PREADY = rdy;   PSLVERR = err;  PRDATA = rdata;
  endtask

  // Inputs change 2 time units after the rising edge; outputs are read 1 later.
  task automatic tick;
    @(posedge PCLK);
    #2;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic runVector(input vec_t v);
    logic [31:0] a1;
    logic [31:0] d1;
    logic        w;
    a1 = v.addr ^ 32'h0000_0100;
    d1 = ~v.wdata;
    w  = (v.exp_gnt == GNT_M1);
    tick;
    applyStimulus(v.req0, v.req1, v.addr, a1, v.wr, v.wr, v.wdata, d1,
                  1'b0, 1'b0, v.rdata);
    settle;
    checkOutput("vec_idle_psel", PSEL, 1'b0);
    tick;
    settle;
    checkOutput("vec_setup_psel_pen", {PSEL, PENABLE}, 2'b10);
    checkOutput("vec_setup_gnt", GNT, v.exp_gnt);
    checkOutput("vec_setup_paddr", PADDR, w ? a1 : v.addr);
    checkOutput("vec_setup_pwdata", PWDATA, w ? d1 : v.wdata);
    checkOutput("vec_setup_pwrite", PWRITE, v.wr);
    for (int i = 0; i < v.waits; i++) begin
      tick;
      settle;
      checkOutput("vec_wait_pen", PENABLE, 1'b1);
      checkOutput("vec_wait_pready", {PREADY_M1, PREADY_M0}, 2'b00);
    end
    tick;
    PREADY = 1'b1;
    PSLVERR = v.err;
    settle;
    checkOutput("vec_done_pready", {PREADY_M1, PREADY_M0}, v.exp_gnt);
    checkOutput("vec_done_pslverr", {PSLVERR_M1, PSLVERR_M0},
                v.err ? v.exp_gnt : GNT_NONE);
    checkOutput("vec_done_prdata_win", w ? PRDATA_M1 : PRDATA_M0, v.rdata);
    checkOutput("vec_done_prdata_lose", w ? PRDATA_M0 : PRDATA_M1, 32'h0);
    tick;
    applyStimulus(1'b0, 1'b0, v.addr, a1, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h0);
    settle;
    checkOutput("vec_after_psel_gnt", {PSEL, PENABLE, GNT}, 4'b0000);
    checkOutput("vec_after_paddr_hold", PADDR, w ? a1 : v.addr);
  endtask

  // Randomized-run reference model state: a transfer occupies the window
  // [x_start, x_end]; the first cycle is SETUP, the last is the completion.
  logic        act[2];
  logic [31:0] ra[2];
  logic [31:0] rdw[2];
  logic        rw[2];
  logic        prev_req[2];
  logic        prev_idle;
  logic        in_xfer;
  int          x_start, x_end, owner, m_last;

  initial begin
    logic [1:0] seen_gnt[$];
    int         cnt0, cnt1, budget, cyc;
    logic       was_busy, done, rnd_rdy, rnd_err;
    logic [31:0] rnd_rd;

    vecs[0] = '{1'b1, 1'b0, 32'h7000_0004, 1'b1, 32'hA5A5_5A5A, 0, 1'b0, 32'h0000_0000, GNT_M0};
    vecs[1] = '{1'b1, 1'b1, 32'h7000_0010, 1'b0, 32'h1111_2222, 1, 1'b0, 32'hCAFE_0001, GNT_M1};
    vecs[2] = '{1'b1, 1'b1, 32'h7000_0020, 1'b1, 32'h3333_4444, 0, 1'b0, 32'h0BAD_0002, GNT_M0};
    vecs[3] = '{1'b0, 1'b1, 32'h7000_0030, 1'b1, 32'h5555_6666, 3, 1'b1, 32'h0000_0003, GNT_M1};
    vecs[4] = '{1'b0, 1'b1, 32'h7000_0040, 1'b0, 32'h7777_8888, 2, 1'b0, 32'hFEED_0004, GNT_M1};
    vecs[5] = '{1'b1, 1'b1, 32'h7000_0050, 1'b0, 32'h9999_AAAA, 0, 1'b1, 32'h1234_0005, GNT_M0};
    vecs[6] = '{1'b1, 1'b0, 32'h7000_0060, 1'b1, 32'hBBBB_CCCC, 1, 1'b0, 32'h0000_0006, GNT_M0};
    vecs[7] = '{1'b1, 1'b1, 32'h7000_0070, 1'b0, 32'hDDDD_EEEE, 0, 1'b0, 32'h5678_0007, GNT_M1};

    // Reset values, with a slave PREADY that must not leak upstream.
    PRESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b1, 1'b0, 32'h0);
    #3;
    checkOutput("rst_psel_pen_gnt", {PSEL, PENABLE, GNT}, 4'b0000);
    checkOutput("rst_paddr", PADDR, 32'h0);
    checkOutput("rst_pwdata_pwrite", {PWDATA, PWRITE}, 33'h0);
    checkOutput("rst_pready_m", {PREADY_M1, PREADY_M0}, 2'b00);
    tick;
    PRESET = 1'b0;

    // Both masters read at cycle N: M0 first, M1 completes at N+5.
    tick;
    applyStimulus(1'b1, 1'b1, 32'h4000_0000, 32'h4000_0100, 1'b0, 1'b0,
                  32'h0, 32'h0, 1'b1, 1'b0, 32'h0000_1234);
    settle;
    checkOutput("both_n_gnt", GNT, GNT_NONE);
    tick;
    settle;
    checkOutput("both_n1_setup", {PSEL, PENABLE, GNT}, {2'b10, GNT_M0});
    checkOutput("both_n1_pready", {PREADY_M1, PREADY_M0}, 2'b00);
    checkOutput("both_n1_prdata_m1", PRDATA_M1, 32'h0);
    tick;
    settle;
    checkOutput("both_n2_pready", {PENABLE, PREADY_M1, PREADY_M0}, 3'b101);
    checkOutput("both_n2_prdata_m0", PRDATA_M0, 32'h0000_1234);
    checkOutput("both_n2_prdata_m1", PRDATA_M1, 32'h0);
    tick;
    PSEL_M0 = 1'b0;
    settle;
    checkOutput("both_n3_idle", {PSEL, GNT}, 3'b000);
    tick;
    settle;
    checkOutput("both_n4_setup", {PSEL, PENABLE, GNT}, {2'b10, GNT_M1});
    checkOutput("both_n4_paddr", PADDR, 32'h4000_0100);
    tick;
    settle;
    checkOutput("both_n5_pready", {PREADY_M1, PREADY_M0}, 2'b10);
    checkOutput("both_n5_prdata", {PRDATA_M1, PRDATA_M0}, {32'h0000_1234, 32'h0});
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h0);
    settle;
    checkOutput("both_n6_idle", PSEL, 1'b0);

    for (int i = 0; i < 8; i++) runVector(vecs[i]);

    // Continuous requests from both masters: strict alternation, 4 each.
    cnt0 = 0;
    cnt1 = 0;
    budget = 0;
    while ((cnt0 + cnt1) < 8 && budget < 60) begin
      tick;
      applyStimulus(1'b1, 1'b1, 32'h5000_0000, 32'h5000_0004, 1'b1, 1'b0,
                    32'h0000_00AA, 32'h0000_00BB, 1'b1, 1'b0, 32'h0);
      settle;
      if (PSEL && !PENABLE) seen_gnt.push_back(GNT);
      if (PREADY_M0) cnt0++;
      if (PREADY_M1) cnt1++;
      budget++;
    end
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h0);
    settle;
    checkOutput("alt_count_m0", cnt0, 4);
    checkOutput("alt_count_m1", cnt1, 4);
    checkOutput("alt_cycles", budget, 24);
    checkOutput("alt_setups", seen_gnt.size(), 8);
    for (int i = 0; i < seen_gnt.size() && i < 8; i++)
      checkOutput("alt_gnt", seen_gnt[i], (i % 2 == 0) ? GNT_M0 : GNT_M1);

    // M0 read against a slave that never answers.
    tick;
    applyStimulus(1'b1, 1'b0, 32'h6000_0008, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'hDEAD_BEEF);
    tick;
    settle;
    checkOutput("stall_setup_gnt", GNT, GNT_M0);
`ifdef APB_ARB_TIMEOUT_EN
    for (int k = 1; k <= 3; k++) begin
      tick;
      settle;
      checkOutput("to_wait_pready", {PENABLE, PREADY_M0}, 2'b10);
    end
    tick;
    settle;
    checkOutput("to_abort_pready_err", {PREADY_M0, PSLVERR_M0}, 2'b11);
    checkOutput("to_abort_prdata", PRDATA_M0, 32'h0);
    tick;
    PSEL_M0 = 1'b0;
    settle;
    checkOutput("to_after_psel", {PSEL, PENABLE, GNT}, 4'b0000);
`else
    for (int k = 1; k <= 6; k++) begin
      tick;
      settle;
      checkOutput("stall_wait_pready", {PSEL, PENABLE, PREADY_M0}, 3'b110);
    end
    tick;
    PREADY = 1'b1;
    settle;
    checkOutput("stall_done_pready", {PREADY_M0, PSLVERR_M0}, 2'b10);
    checkOutput("stall_done_prdata", PRDATA_M0, 32'hDEAD_BEEF);
    tick;
    PSEL_M0 = 1'b0;
    PREADY = 1'b0;
    settle;
    checkOutput("stall_after_psel", PSEL, 1'b0);
`endif

    // Randomized run; M0 holds the most recent grant at this point.
    m_last = 0;
    in_xfer = 1'b0;
    prev_idle = 1'b1;
    owner = 0;
    x_start = 0;
    x_end = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; prev_req[m] = 1'b0;
      ra[m] = '0; rdw[m] = '0; rw[m] = 1'b0;
    end
    cyc = 0;
    while ((cyc < 400 || in_xfer || act[0] || act[1]) && cyc < 600) begin
      tick;
      if (!in_xfer && prev_idle && (prev_req[0] || prev_req[1])) begin
        if (prev_req[0] && prev_req[1]) owner = 1 - m_last;
        else                            owner = prev_req[1] ? 1 : 0;
        m_last  = owner;
        in_xfer = 1'b1;
        x_start = cyc;
        x_end   = cyc + 1 + int'($urandom_range(0, 2));
      end
      for (int m = 0; m < 2; m++) begin
        if (!act[m] && cyc < 400 && $urandom_range(0, 2) != 0) begin
          act[m] = 1'b1;
          ra[m]  = $urandom;
          rdw[m] = $urandom;
          rw[m]  = $urandom_range(0, 1) == 1;
        end
      end
      rnd_rd  = $urandom;
      rnd_err = $urandom_range(0, 1) == 1;
      if (in_xfer && cyc == x_end)        rnd_rdy = 1'b1;
      else if (in_xfer && cyc > x_start)  rnd_rdy = 1'b0;
      else                                rnd_rdy = $urandom_range(0, 1) == 1;
      applyStimulus(act[0], act[1], ra[0], ra[1], rw[0], rw[1], rdw[0], rdw[1],
                    rnd_rdy, rnd_err, rnd_rd);
      settle;
      done = in_xfer && (cyc == x_end);
      checkOutput("rnd_psel_pen_gnt", {PSEL, PENABLE, GNT},
                  {in_xfer, in_xfer && (cyc > x_start),
                   in_xfer ? (owner == 1 ? GNT_M1 : GNT_M0) : GNT_NONE});
      if (in_xfer)
        checkOutput("rnd_req_copy", {PADDR, PWDATA, PWRITE},
                    {ra[owner], rdw[owner], rw[owner]});
      checkOutput("rnd_pready_err",
                  {PREADY_M1, PREADY_M0, PSLVERR_M1, PSLVERR_M0},
                  {done && owner == 1, done && owner == 0,
                   done && owner == 1 && rnd_err, done && owner == 0 && rnd_err});
      checkOutput("rnd_prdata_m0", PRDATA_M0,
                  (in_xfer && owner == 0) ? rnd_rd : 32'h0);
      checkOutput("rnd_prdata_m1", PRDATA_M1,
                  (in_xfer && owner == 1) ? rnd_rd : 32'h0);
      was_busy = in_xfer;
      for (int m = 0; m < 2; m++) prev_req[m] = act[m];
      if (done) begin
        act[owner] = 1'b0;
        in_xfer = 1'b0;
      end
      prev_idle = !was_busy;
      cyc++;
    end
    checkOutput("rnd_drained", {in_xfer, act[0], act[1]}, 3'b000);
    tick;
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0,
                  1'b0, 1'b0, 32'h0);

    // Reset during an M0 ACCESS, then both request: M0 must win again.
    tick;
    applyStimulus(1'b1, 1'b0, 32'h0000_0C00, 32'h0000_0D00, 1'b0, 1'b0,
                  32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick;
    tick;
    settle;
    checkOutput("rstmid_access", {PSEL, PENABLE, GNT}, {2'b11, GNT_M0});
    PRESET = 1'b1;
    #1;
    checkOutput("rstmid_async_clear", {PSEL, PENABLE, GNT}, 4'b0000);
    PSEL_M1 = 1'b1;
    PREADY = 1'b1;
    tick;
    tick;
    PRESET = 1'b0;
    settle;
    checkOutput("rstmid_released_idle", PSEL, 1'b0);
    tick;
    settle;
    checkOutput("rstmid_first_gnt", {PSEL, PENABLE, GNT}, {2'b10, GNT_M0});
    checkOutput("rstmid_first_paddr", PADDR, 32'h0000_0C00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
